// File: rtl/ro_freq_meter.sv
// Ring-oscillator frequency meter: arms the oscillator, then counts rising edges of
// one synchronized tap over a programmable gate window and reports a saturating count.
module ro_freq_meter #(
  parameter int CNT_W  = 16,
  parameter int GATE_W = 16,
  parameter int SETTLE = 8
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  input  logic              meas_req,
  input  logic [4:0]        cfg_sel,
  input  logic [2:0]        tap_sel,
  input  logic [GATE_W-1:0] gate_len,
  output logic              s1,
  output logic              s2,
  output logic              s3,
  output logic              s4,
  output logic              s5,
  output logic              start,
  input  logic              X1_Y1,
  input  logic              X2_Y1,
  input  logic              X3_Y1,
  input  logic              X4_Y1,
  input  logic              X5_Y1,
  output logic              meas_busy,
  output logic              meas_done,
  output logic [CNT_W-1:0]  meas_count,
  output logic              meas_ovf
);

  localparam int SET_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {IDLE, ARM, GATE, DONE} state_t;
  state_t state, state_nxt;

  logic [4:0]        x_in, x_meta, x_sync, x_sync_d, x_rise;
  logic [4:0]        sel_q;
  logic [2:0]        tap_q;
  logic              gate_zero;
  logic [GATE_W-1:0] gate_cnt;
  logic [SET_W-1:0]  settle_cnt;
  logic [CNT_W-1:0]  edge_cnt, edge_cnt_nxt;
  logic              ovf_q, ovf_nxt;
  logic              tap_rise;

  assign x_in = {X5_Y1, X4_Y1, X3_Y1, X2_Y1, X1_Y1};

  // 2-flop synchronizer per tap plus one delay stage for edge detection
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      x_meta   <= '0;
      x_sync   <= '0;
      x_sync_d <= '0;
    end else begin
      x_meta   <= x_in;
      x_sync   <= x_meta;
      x_sync_d <= x_sync;
    end
  end

  assign x_rise = x_sync & ~x_sync_d;

  // Out-of-range taps select nothing, so the measurement returns 0
  always_comb begin
    tap_rise = 1'b0;
    case (tap_q)
      3'd0:    tap_rise = x_rise[0];
      3'd1:    tap_rise = x_rise[1];
      3'd2:    tap_rise = x_rise[2];
      3'd3:    tap_rise = x_rise[3];
      3'd4:    tap_rise = x_rise[4];
      default: tap_rise = 1'b0;
    endcase
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (meas_req) state_nxt = ARM;
      ARM:  if (settle_cnt == '0) state_nxt = gate_zero ? DONE : GATE;
      GATE: if (gate_cnt == '0) state_nxt = DONE;
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Overflow flags an edge that arrived while the counter was already pinned
  always_comb begin
    edge_cnt_nxt = edge_cnt;
    ovf_nxt      = ovf_q;
    if (state == GATE && tap_rise) begin
      if (edge_cnt == CNT_MAX) ovf_nxt = 1'b1;
      else                     edge_cnt_nxt = edge_cnt + 1'b1;
    end
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state      <= IDLE;
      sel_q      <= '0;
      tap_q      <= '0;
      gate_zero  <= 1'b0;
      gate_cnt   <= '0;
      settle_cnt <= '0;
      edge_cnt   <= '0;
      ovf_q      <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: if (meas_req) begin
          sel_q      <= cfg_sel;
          tap_q      <= tap_sel;
          gate_zero  <= (gate_len == '0);
          gate_cnt   <= gate_len - GATE_W'(1);
          settle_cnt <= SET_W'(SETTLE - 1);
          edge_cnt   <= '0;
          ovf_q      <= 1'b0;
        end
        ARM:  if (settle_cnt != '0) settle_cnt <= settle_cnt - 1'b1;
        GATE: begin
          if (gate_cnt != '0) gate_cnt <= gate_cnt - 1'b1;
          edge_cnt <= edge_cnt_nxt;
          ovf_q    <= ovf_nxt;
        end
        default: ;
      endcase
    end
  end

  // Outputs are registered from the next state so they align with the state itself
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      start      <= 1'b0;
      meas_busy  <= 1'b0;
      meas_done  <= 1'b0;
      meas_count <= '0;
      meas_ovf   <= 1'b0;
    end else begin
      start     <= (state_nxt == ARM) || (state_nxt == GATE);
      meas_busy <= (state_nxt != IDLE);
      meas_done <= (state_nxt == DONE);
      if (state_nxt == DONE) begin
        meas_count <= edge_cnt_nxt;
        meas_ovf   <= ovf_nxt;
      end
    end
  end

  assign {s5, s4, s3, s2, s1} = sel_q;

endmodule

// File: tb/tb_ro_freq_meter.sv
// Directed bench for ro_freq_meter: timing, counting, saturation, abort and request handling.
module tb_ro_freq_meter;

  logic        clk = 1'b0;
  logic        rst;
  logic        meas_req;
  logic [4:0]  cfg_sel;
  logic [2:0]  tap_sel;
  logic [15:0] gate_len;
  logic [4:0]  x;
  logic        s1, s2, s3, s4, s5, start, meas_busy, meas_done, meas_ovf;
  logic [15:0] meas_count;
  logic        d4_s1, d4_s2, d4_s3, d4_s4, d4_s5, d4_start, d4_busy, d4_done, d4_ovf;
  logic [3:0]  d4_count;

  int nvec = 0;
  int nerr = 0;
  int per[5];
  int ph[5];
  int done_pulses = 0;

  always #5 clk = ~clk;

  ro_freq_meter #(.CNT_W(16), .GATE_W(16), .SETTLE(8)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst), .meas_req(meas_req), .cfg_sel(cfg_sel),
    .tap_sel(tap_sel), .gate_len(gate_len),
    .s1(s1), .s2(s2), .s3(s3), .s4(s4), .s5(s5), .start(start),
    .X1_Y1(x[0]), .X2_Y1(x[1]), .X3_Y1(x[2]), .X4_Y1(x[3]), .X5_Y1(x[4]),
    .meas_busy(meas_busy), .meas_done(meas_done), .meas_count(meas_count), .meas_ovf(meas_ovf)
  );

  ro_freq_meter #(.CNT_W(4), .GATE_W(16), .SETTLE(8)) dut4 (
    .wb_clk_i(clk), .wb_rst_i(rst), .meas_req(meas_req), .cfg_sel(cfg_sel),
    .tap_sel(tap_sel), .gate_len(gate_len),
    .s1(d4_s1), .s2(d4_s2), .s3(d4_s3), .s4(d4_s4), .s5(d4_s5), .start(d4_start),
    .X1_Y1(x[0]), .X2_Y1(x[1]), .X3_Y1(x[2]), .X4_Y1(x[3]), .X5_Y1(x[4]),
    .meas_busy(d4_busy), .meas_done(d4_done), .meas_count(d4_count), .meas_ovf(d4_ovf)
  );

  // Oscillator models: tap i has period per[i] clocks (50% duty), 0 = held low
  initial begin
    x = '0;
    for (int i = 0; i < 5; i++) begin per[i] = 0; ph[i] = 0; end
    forever begin
      @(negedge clk);
      for (int i = 0; i < 5; i++) begin
        if (per[i] == 0) x[i] = 1'b0;
        else begin
          ph[i] = (ph[i] + 1) % per[i];
          x[i]  = (ph[i] < per[i] / 2);
        end
      end
    end
  end

  initial forever begin
    @(negedge clk);
    if (meas_done) done_pulses++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_rng(input string tag, input logic [31:0] obs, input int lo, input int hi);
    nvec++;
    assert (obs >= lo && obs <= hi) else begin
      nerr++;
      $error("FAIL %s: observed %0d expected %0d..%0d", tag, obs, lo, hi);
    end
  endtask

  // Issue one request; k counts cycles after the accepting edge t0. Returns in the IDLE cycle after DONE.
  task automatic do_meas(input logic [4:0] cfg, input logic [2:0] tap, input logic [15:0] gl,
                         input int p1, input int p2,
                         output int done_k, output int start_cnt, output int busy_cnt,
                         output logic s_ok);
    int k;
    @(negedge clk);
    cfg_sel = cfg; tap_sel = tap; gate_len = gl; meas_req = 1'b1;
    @(negedge clk);
    meas_req = 1'b0;
    k = 1; done_k = -1; start_cnt = 0; busy_cnt = 0;
    s_ok = ({s5, s4, s3, s2, s1} === cfg);
    while (done_k < 0 && k < 1000) begin
      if (start) start_cnt++;
      if (meas_busy) busy_cnt++;
      if (meas_done) done_k = k;
      else begin
        meas_req = (k == p1 || k == p2);
        @(negedge clk);
        k++;
      end
    end
    meas_req = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    int dk, sc, bc, w, seen_start, seen_busy, dp0;
    logic sok;
    rst = 1'b1; meas_req = 1'b0; cfg_sel = '0; tap_sel = '0; gate_len = '0;
    repeat (3) @(negedge clk);

    // reset state
    chk("rst_start", start, 0);
    chk("rst_busy", meas_busy, 0);
    chk("rst_done", meas_done, 0);
    chk("rst_count", meas_count, 0);
    chk("rst_ovf", meas_ovf, 0);
    chk("rst_s", {s5, s4, s3, s2, s1}, 0);

    rst = 1'b0;
    seen_start = 0; seen_busy = 0;
    repeat (100) begin
      @(negedge clk);
      if (start) seen_start++;
      if (meas_busy) seen_busy++;
    end
    chk("idle_start", seen_start, 0);
    chk("idle_busy", seen_busy, 0);

    // basic: tap 3 at clk/10, 100-cycle gate -> ~10 edges, DONE at t0+109
    per[2] = 10;
    repeat (20) @(negedge clk);
    do_meas(5'b10110, 3'd2, 16'd100, -1, -1, dk, sc, bc, sok);
    chk("basic_done_k", dk, 109);
    chk("basic_start_cycles", sc, 108);
    chk("basic_busy_cycles", bc, 109);
    chk("basic_s_at_t1", sok, 1);
    chk_rng("basic_count", meas_count, 9, 11);
    chk("basic_ovf", meas_ovf, 0);
    chk("basic_idle_busy", meas_busy, 0);
    chk("basic_s_hold", {s5, s4, s3, s2, s1}, 5'b10110);

    // overflow: tap 1 at clk/4, 200-cycle gate -> ~50 edges; 4-bit counter saturates
    per[2] = 0; per[0] = 4;
    do_meas(5'b00001, 3'd0, 16'd200, -1, -1, dk, sc, bc, sok);
    chk("ovf_done_k", dk, 209);
    chk_rng("ovf_count16", meas_count, 49, 51);
    chk("ovf_ovf16", meas_ovf, 0);
    chk("ovf_count4", d4_count, 15);
    chk("ovf_ovf4", d4_ovf, 1);

    // abort in GATE: start drops asynchronously, no DONE, result cleared
    @(negedge clk);
    cfg_sel = 5'b00011; tap_sel = 3'd0; gate_len = 16'd100; meas_req = 1'b1;
    @(negedge clk);
    meas_req = 1'b0;
    repeat (20) @(negedge clk);
    chk("abort_pre_start", start, 1);
    dp0 = done_pulses;
    #1 rst = 1'b1;
    #1 chk("abort_start", start, 0);
    repeat (3) @(negedge clk);
    chk("abort_count", meas_count, 0);
    chk("abort_busy", meas_busy, 0);
    rst = 1'b0;
    repeat (150) @(negedge clk);
    chk("abort_no_done", done_pulses - dp0, 0);
    per[0] = 0; per[2] = 10;
    do_meas(5'b01000, 3'd2, 16'd20, -1, -1, dk, sc, bc, sok);
    chk("after_abort_done_k", dk, 29);
    chk_rng("after_abort_count", meas_count, 1, 3);

    // zero gate: DONE right after ARM, nothing counted
    do_meas(5'b11111, 3'd2, 16'd0, -1, -1, dk, sc, bc, sok);
    chk("zero_done_k", dk, 9);
    chk("zero_start_cycles", sc, 8);
    chk("zero_count", meas_count, 0);

    // invalid tap with every tap toggling
    for (int i = 0; i < 5; i++) per[i] = 4;
    do_meas(5'b00100, 3'd6, 16'd50, -1, -1, dk, sc, bc, sok);
    chk("badtap_done_k", dk, 59);
    chk("badtap_count", meas_count, 0);
    chk("badtap_ovf", meas_ovf, 0);

    // request pulses during ARM and GATE are dropped
    for (int i = 0; i < 5; i++) per[i] = 0;
    per[2] = 10;
    dp0 = done_pulses;
    do_meas(5'b00010, 3'd2, 16'd30, 3, 20, dk, sc, bc, sok);
    chk("ign_done_k", dk, 39);
    repeat (60) @(negedge clk);
    chk("ign_one_done", done_pulses - dp0, 1);

    // held request: DONE every SETTLE+gate_len+2 = 20 clocks
    gate_len = 16'd10; tap_sel = 3'd2; cfg_sel = 5'b00101;
    meas_req = 1'b1;
    w = 0;
    do begin @(negedge clk); w++; end while (!meas_done && w < 200);
    chk("b2b_first_done", meas_done, 1);
    for (int r = 0; r < 2; r++) begin
      w = 0;
      do begin @(negedge clk); w++; end while (!meas_done && w < 200);
      chk("b2b_spacing", w, 20);
    end
    meas_req = 1'b0;
    repeat (5) @(negedge clk);
    chk("b2b_idle_busy", meas_busy, 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
